// File: rtl/load_store_unit_if.sv
// Request/response handshake and data_memory port bundle for load_store_unit.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_address;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic [1:0]  resp_error_code;
   logic        mem_read_enable;
   logic        mem_write_enable;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   // Execute stage plus data_memory side
   modport master (
      output req_valid, req_write, req_funct3, req_address, req_wdata,
      output resp_ready, mem_read_data,
      input  req_ready, resp_valid, resp_rdata, resp_error, resp_error_code,
      input  mem_read_enable, mem_write_enable, mem_address, mem_write_data
   );

   // The load/store unit itself
   modport slave (
      input  req_valid, req_write, req_funct3, req_address, req_wdata,
      input  resp_ready, mem_read_data,
      output req_ready, resp_valid, resp_rdata, resp_error, resp_error_code,
      output mem_read_enable, mem_write_enable, mem_address, mem_write_data
   );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: byte-addressed RISC-V loads/stores mapped onto a
// word-indexed data_memory, with read-modify-write for sub-word stores.
module load_store_unit #(
   parameter int unsigned MEM_WORDS = 1024
) (
   input logic             clock,
   input logic             reset,
   load_store_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t      state;
   state_t      state_next;

   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [2:0]  funct3_q;
   logic        write_q;
   logic [31:0] word_q;
   logic [31:0] rdata_q;
   logic        error_q;
   logic [1:0]  code_q;

   logic [1:0]  check_code;
   logic [31:0] lane_shift;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] load_value;
   logic [31:0] store_word;

   // Fault classification of the incoming request, highest precedence first
   always_comb begin
      check_code = 2'b00;
      if (bus.req_write ? (bus.req_funct3 > 3'd2)
                        : (bus.req_funct3 == 3'd3 || bus.req_funct3[2:1] == 2'b11))
         check_code = 2'b11;
      else if ((bus.req_funct3[1:0] == 2'd1 && bus.req_address[0]) ||
               (bus.req_funct3[1:0] == 2'd2 && bus.req_address[1:0] != 2'b00))
         check_code = 2'b01;
      else if ({2'b00, bus.req_address[31:2]} >= MEM_WORDS)
         check_code = 2'b10;
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state selection
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               if (check_code != 2'b00)
                  state_next = RESP;
               else if (bus.req_write && bus.req_funct3 == 3'd2)
                  state_next = WRITE;
               else
                  state_next = READ;
            end
         end
         READ:    state_next = write_q ? WRITE : RESP;
         WRITE:   state_next = RESP;
         RESP:    state_next = bus.resp_ready ? IDLE : RESP;
         default: state_next = IDLE;
      endcase
   end

   // Lane extraction of the word arriving from data_memory (feeds a register only)
   always_comb begin
      lane_shift = bus.mem_read_data >> {addr_q[1:0], 3'b000};
      lane_byte  = lane_shift[7:0];
      lane_half  = addr_q[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
      case (funct3_q)
         3'd0:    load_value = {{24{lane_byte[7]}}, lane_byte};
         3'd1:    load_value = {{16{lane_half[15]}}, lane_half};
         3'd2:    load_value = bus.mem_read_data;
         3'd4:    load_value = {24'b0, lane_byte};
         3'd5:    load_value = {16'b0, lane_half};
         default: load_value = '0;
      endcase
   end

   // Merge of store data into the captured word
   always_comb begin
      store_word = wdata_q;
      case (funct3_q[1:0])
         2'd0: begin
            store_word = word_q;
            store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         end
         2'd1: begin
            store_word = word_q;
            store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         end
         default: store_word = wdata_q;
      endcase
   end

   // Request latch, read-word capture and response registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         funct3_q <= '0;
         write_q  <= 1'b0;
         word_q   <= '0;
         rdata_q  <= '0;
         error_q  <= 1'b0;
         code_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  addr_q   <= bus.req_address;
                  wdata_q  <= bus.req_wdata;
                  funct3_q <= bus.req_funct3;
                  write_q  <= bus.req_write;
                  error_q  <= (check_code != 2'b00);
                  code_q   <= check_code;
                  rdata_q  <= '0;
               end
            end
            READ: begin
               word_q <= bus.mem_read_data;
               if (!write_q)
                  rdata_q <= load_value;
            end
            default: ;
         endcase
      end
   end

   // Moore outputs decoded from the current state
   always_comb begin
      bus.req_ready        = (state == IDLE);
      bus.resp_valid       = (state == RESP);
      bus.mem_read_enable  = (state == READ);
      bus.mem_write_enable = (state == WRITE);
      bus.mem_address      = (state == READ || state == WRITE) ? {2'b00, addr_q[31:2]} : '0;
      bus.mem_write_data   = (state == WRITE) ? store_word : '0;
      bus.resp_rdata       = (state == RESP) ? rdata_q : '0;
      bus.resp_error       = (state == RESP) && error_q;
      bus.resp_error_code  = (state == RESP) ? code_q : '0;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural data_memory.
module tb_load_store_unit;

   localparam int unsigned MEM_WORDS = 1024;

   logic clock;
   logic reset;

   load_store_unit_if bus ();

   load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [31:0] mem     [MEM_WORDS];
   logic [31:0] ref_mem [MEM_WORDS];

   always @(posedge clock)
      if (bus.mem_write_enable && bus.mem_address < MEM_WORDS)
         mem[bus.mem_address[9:0]] <= bus.mem_write_data;

   assign bus.mem_read_data = (bus.mem_address < MEM_WORDS) ? mem[bus.mem_address[9:0]] : '0;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] last_rdata;
   logic [1:0]  last_code;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic poke(input int unsigned idx, input logic [31:0] val);
      mem[idx] <= val;
      ref_mem[idx] = val;
   endtask

   // One complete transaction, expectations from a byte-level reference model
   task automatic run_op(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] erd;
      logic [31:0] enew;
      logic [1:0]  ecode;
      int          elat;
      int          lat;
      int unsigned size;
      int unsigned off;
      int unsigned idx;
      longint unsigned m;
      longint unsigned v;
      longint unsigned old;
      bit          legal;
      bit          saw_rd;
      bit          saw_wr;
      bit          both;

      legal = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      if (!legal)                 ecode = 2'b11;
      else if (a % size != 0)     ecode = 2'b01;
      else if (a / 4 >= MEM_WORDS) ecode = 2'b10;
      else                        ecode = 2'b00;
      erd  = '0;
      enew = '0;
      idx  = a / 4;
      off  = a % 4;
      elat = 1;
      if (ecode == 2'b00) begin
         old = longint'(ref_mem[idx]);
         m   = (64'd1 << (8 * size)) - 1;
         if (!w) begin
            v = (old >> (8 * off)) & m;
            if (f3 < 3'd4 && size < 4 && ((v >> (8 * size - 1)) & 1) == 1)
               v = v | (~m & 64'hFFFF_FFFF);
            erd  = v[31:0];
            elat = 2;
         end else begin
            v    = (old & ~(m << (8 * off))) | ((longint'(wd) & m) << (8 * off));
            enew = v[31:0];
            elat = (size == 4) ? 2 : 3;
         end
      end

      check("req_ready before request", 32'(bus.req_ready), 32'd1);
      bus.req_valid   = 1'b1;
      bus.req_write   = w;
      bus.req_funct3  = f3;
      bus.req_address = a;
      bus.req_wdata   = wd;
      @(negedge clock);
      bus.req_valid   = 1'b0;
      bus.req_write   = ~w;
      bus.req_funct3  = 3'($urandom);
      bus.req_address = $urandom;
      bus.req_wdata   = $urandom;

      lat    = 1;
      saw_rd = 1'b0;
      saw_wr = 1'b0;
      both   = 1'b0;
      while (!bus.resp_valid && lat < 8) begin
         saw_rd |= bus.mem_read_enable;
         saw_wr |= bus.mem_write_enable;
         both   |= bus.mem_read_enable & bus.mem_write_enable;
         @(negedge clock);
         lat++;
      end
      check("latency", 32'(lat), 32'(elat));
      check("resp_rdata", bus.resp_rdata, erd);
      check("resp_error", 32'(bus.resp_error), 32'(ecode != 2'b00));
      check("resp_error_code", 32'(bus.resp_error_code), 32'(ecode));
      check("read cycle seen", 32'(saw_rd), 32'(ecode == 2'b00 && !(w && size == 4)));
      check("write cycle seen", 32'(saw_wr), 32'(ecode == 2'b00 && w));
      check("enables exclusive", 32'(both), 32'd0);
      check("enables low in RESP", 32'({bus.mem_read_enable, bus.mem_write_enable}), 32'd0);
      last_rdata = bus.resp_rdata;
      last_code  = bus.resp_error_code;

      bus.resp_ready = 1'b1;
      @(negedge clock);
      bus.resp_ready = 1'b0;
      check("resp_valid after release", 32'(bus.resp_valid), 32'd0);
      check("req_ready after release", 32'(bus.req_ready), 32'd1);

      if (ecode == 2'b00 && w) begin
         ref_mem[idx] = enew;
         check("memory word after store", mem[idx], enew);
      end
   endtask

   initial begin
      logic        w;
      logic [2:0]  f3;
      logic [31:0] a;
      int unsigned word;
      int          lat;

      reset           = 1'b1;
      bus.req_valid   = 1'b0;
      bus.req_write   = 1'b0;
      bus.req_funct3  = '0;
      bus.req_address = '0;
      bus.req_wdata   = '0;
      bus.resp_ready  = 1'b0;
      for (int unsigned i = 0; i < MEM_WORDS; i++)
         poke(i, $urandom);

      #12;
      check("reset req_ready", 32'(bus.req_ready), 32'd1);
      check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
      check("reset resp_rdata", bus.resp_rdata, 32'd0);
      check("reset resp_error", 32'(bus.resp_error), 32'd0);
      check("reset resp_error_code", 32'(bus.resp_error_code), 32'd0);
      check("reset mem_read_enable", 32'(bus.mem_read_enable), 32'd0);
      check("reset mem_write_enable", 32'(bus.mem_write_enable), 32'd0);
      check("reset mem_address", bus.mem_address, 32'd0);
      check("reset mem_write_data", bus.mem_write_data, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // SW then LW
      run_op(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
      check("SW word 4", mem[4], 32'hDEADBEEF);
      run_op(1'b0, 3'd2, 32'h10, 32'h0);
      check("LW 0x10", last_rdata, 32'hDEADBEEF);

      // Sub-word loads
      poke(4, 32'h8001_7F80);
      run_op(1'b0, 3'd0, 32'h10, 32'h0);
      check("LB 0x10", last_rdata, 32'hFFFFFF80);
      run_op(1'b0, 3'd4, 32'h10, 32'h0);
      check("LBU 0x10", last_rdata, 32'h00000080);
      run_op(1'b0, 3'd1, 32'h12, 32'h0);
      check("LH 0x12", last_rdata, 32'hFFFF8001);
      run_op(1'b0, 3'd5, 32'h12, 32'h0);
      check("LHU 0x12", last_rdata, 32'h00008001);
      run_op(1'b0, 3'd0, 32'h11, 32'h0);
      check("LB 0x11", last_rdata, 32'h0000007F);

      // Read-modify-write stores
      poke(5, 32'h1122_3344);
      run_op(1'b1, 3'd0, 32'h16, 32'hFFFF_FFAB);
      check("SB 0x16", mem[5], 32'h11AB3344);
      run_op(1'b1, 3'd1, 32'h14, 32'h1234_BEEF);
      check("SH 0x14", mem[5], 32'h11ABBEEF);

      // Faults
      run_op(1'b0, 3'd2, 32'h13, 32'h0);
      check("LW 0x13 code", 32'(last_code), 32'd1);
      run_op(1'b0, 3'd2, 32'h1000, 32'h0);
      check("LW 0x1000 code", 32'(last_code), 32'd2);
      run_op(1'b1, 3'd4, 32'h20, 32'h5A5A5A5A);
      check("store funct3 4 code", 32'(last_code), 32'd3);
      run_op(1'b0, 3'd3, 32'h13, 32'h0);
      check("load funct3 3 precedence", 32'(last_code), 32'd3);
      run_op(1'b0, 3'd2, 32'hFFC, 32'h0);
      check("LW last word", last_rdata, ref_mem[1023]);

      // Randomized traffic
      for (int n = 0; n < 80; n++) begin
         w = 1'($urandom);
         if ($urandom_range(0, 3) == 0)
            f3 = 3'($urandom);
         else if (w)
            f3 = 3'($urandom_range(0, 2));
         else begin
            f3 = 3'($urandom_range(0, 4));
            if (f3 == 3'd3) f3 = 3'd5;
         end
         word = ($urandom_range(0, 9) == 0) ? $urandom_range(1020, 1030) : $urandom_range(0, 31);
         a = 32'(word * 4 + (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 3)));
         run_op(w, f3, a, $urandom);
      end

      // Backpressure on a load response
      poke(7, 32'hC0FF_EE42);
      bus.req_valid   = 1'b1;
      bus.req_write   = 1'b0;
      bus.req_funct3  = 3'd2;
      bus.req_address = 32'h1C;
      @(negedge clock);
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.resp_valid && lat < 8) begin
         @(negedge clock);
         lat++;
      end
      check("backpressure latency", 32'(lat), 32'd2);
      check("backpressure rdata", bus.resp_rdata, 32'hC0FFEE42);
      for (int k = 0; k < 5; k++) begin
         bus.req_valid   = 1'b1;
         bus.req_write   = 1'b1;
         bus.req_funct3  = 3'd2;
         bus.req_address = 32'h1C;
         bus.req_wdata   = 32'h0BAD_0BAD;
         @(negedge clock);
         check("held resp_valid", 32'(bus.resp_valid), 32'd1);
         check("held resp_rdata", bus.resp_rdata, 32'hC0FFEE42);
         check("held req_ready", 32'(bus.req_ready), 32'd0);
         check("held no write", 32'(bus.mem_write_enable), 32'd0);
      end
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      @(negedge clock);
      bus.resp_ready = 1'b0;
      check("backpressure release resp_valid", 32'(bus.resp_valid), 32'd0);
      check("backpressure release req_ready", 32'(bus.req_ready), 32'd1);
      check("ignored store left word", mem[7], 32'hC0FFEE42);

      // Reset during the WRITE cycle of an SB
      poke(9, 32'h5566_7788);
      bus.req_valid   = 1'b1;
      bus.req_write   = 1'b1;
      bus.req_funct3  = 3'd0;
      bus.req_address = 32'h25;
      bus.req_wdata   = 32'h99;
      @(negedge clock);
      bus.req_valid = 1'b0;
      @(negedge clock);
      check("SB reached WRITE", 32'(bus.mem_write_enable), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("reset drops write enable", 32'(bus.mem_write_enable), 32'd0);
      check("reset req_ready mid-write", 32'(bus.req_ready), 32'd1);
      check("reset resp_valid mid-write", 32'(bus.resp_valid), 32'd0);
      @(negedge clock);
      check("aborted SB left word", mem[9], 32'h55667788);
      reset = 1'b0;
      @(negedge clock);
      check("idle after reset release", 32'(bus.req_ready), 32'd1);
      run_op(1'b0, 3'd2, 32'h24, 32'h0);
      check("LW after aborted SB", last_rdata, 32'h55667788);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
